// File: rtl/pipe_ctrl_regs.sv
// Control-signal pipeline registers for the Decode->Execute->Memory->Writeback path,
// with a small FSM that holds Execute while an external multi-cycle divider runs.
module pipe_ctrl_regs #(
  parameter int ALUCW      = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memtoregD,
  input  logic             memwriteD,
  input  logic             alusrcD,
  input  logic             regdstD,
  input  logic             regwriteD,
  input  logic             hilo_writeD,
  input  logic             divD,
  input  logic [ALUCW-1:0] alucontrolD,
  input  logic             branchD,
  input  logic             equalD,
  input  logic             stallD,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE,
  input  logic             flushM,
  input  logic             flushW,
  output logic             pcsrcD,
  output logic             memtoregE,
  output logic             alusrcE,
  output logic             regdstE,
  output logic             regwriteE,
  output logic             validE,
  output logic [ALUCW-1:0] alucontrolE,
  output logic             memtoregM,
  output logic             memwriteM,
  output logic             regwriteM,
  output logic             hilo_writeM,
  output logic             validM,
  output logic             memtoregW,
  output logic             regwriteW,
  output logic             validW,
  output logic             div_start,
  output logic             div_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  typedef struct packed {
    logic             memtoreg;
    logic             memwrite;
    logic             alusrc;
    logic             regdst;
    logic             regwrite;
    logic             hilo_write;
    logic             div;
    logic [ALUCW-1:0] alucontrol;
    logic             valid;
  } e_fields_t;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
    logic hilo_write;
    logic valid;
  } m_fields_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic valid;
  } w_fields_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  e_fields_t  e_q, e_d;
  m_fields_t  m_q, m_d;
  w_fields_t  w_q, w_d;
  div_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       stall_e_eff;

  assign pcsrcD      = branchD & equalD & ~stallD;
  assign stall_e_eff = stallE | div_stall;

  // Divide sequencer: launch from IDLE, count down in BUSY, release Execute in DONE.
  // Outputs depend only on state, E-stage registers and flushE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    div_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (e_q.valid && e_q.div && !flushE) begin
          div_start = 1'b1;
          div_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = DIV_LOAD;
        end
      end
      BUSY: begin
        div_stall = 1'b1;
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE: begin
        // Stay here under an external hold so the same divide is not relaunched.
        if (!stallE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flushE) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end
  end

  always_comb begin
    e_d = e_q;
    if (flushE) begin
      e_d = '0;
    end else if (!stall_e_eff) begin
      e_d.memtoreg   = memtoregD;
      e_d.memwrite   = memwriteD;
      e_d.alusrc     = alusrcD;
      e_d.regdst     = regdstD;
      e_d.regwrite   = regwriteD;
      e_d.hilo_write = hilo_writeD;
      e_d.div        = divD;
      e_d.alucontrol = alucontrolD;
      e_d.valid      = 1'b1;
    end
  end

  // A held Execute stage sends bubbles downstream rather than duplicating its op.
  always_comb begin
    m_d = m_q;
    if (flushM) begin
      m_d = '0;
    end else if (!stallM) begin
      if (stall_e_eff) begin
        m_d = '0;
      end else begin
        m_d.memtoreg   = e_q.memtoreg;
        m_d.memwrite   = e_q.memwrite;
        m_d.regwrite   = e_q.regwrite;
        m_d.hilo_write = e_q.hilo_write;
        m_d.valid      = e_q.valid;
      end
    end
  end

  always_comb begin
    w_d = '0;
    if (!flushW && !stallM) begin
      w_d.memtoreg = m_q.memtoreg;
      w_d.regwrite = m_q.regwrite;
      w_d.valid    = m_q.valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memtoregE   = e_q.memtoreg;
  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign regwriteE   = e_q.regwrite;
  assign validE      = e_q.valid;
  assign alucontrolE = e_q.alucontrol;
  assign memtoregM   = m_q.memtoreg;
  assign memwriteM   = m_q.memwrite;
  assign regwriteM   = m_q.regwrite;
  assign hilo_writeM = m_q.hilo_write;
  assign validM      = m_q.valid;
  assign memtoregW   = w_q.memtoreg;
  assign regwriteW   = w_q.regwrite;
  assign validW      = w_q.valid;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Bench for pipe_ctrl_regs: behavioural pipeline/divide model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_ctrl_regs;
  localparam int AW = 5;
  localparam int DC = 32;

  logic clk, rst;
  logic memtoregD, memwriteD, alusrcD, regdstD, regwriteD, hilo_writeD, divD;
  logic [AW-1:0] alucontrolD;
  logic branchD, equalD, stallD, stallE, stallM, flushE, flushM, flushW;
  logic pcsrcD, memtoregE, alusrcE, regdstE, regwriteE, validE;
  logic [AW-1:0] alucontrolE;
  logic memtoregM, memwriteM, regwriteM, hilo_writeM, validM;
  logic memtoregW, regwriteW, validW, div_start, div_stall;

  pipe_ctrl_regs #(.ALUCW(AW), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD),
    .regwriteD(regwriteD), .hilo_writeD(hilo_writeD), .divD(divD), .alucontrolD(alucontrolD),
    .branchD(branchD), .equalD(equalD), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .flushW(flushW), .pcsrcD(pcsrcD),
    .memtoregE(memtoregE), .alusrcE(alusrcE), .regdstE(regdstE), .regwriteE(regwriteE),
    .validE(validE), .alucontrolE(alucontrolE), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .regwriteM(regwriteM), .hilo_writeM(hilo_writeM), .validM(validM),
    .memtoregW(memtoregW), .regwriteW(regwriteW), .validW(validW),
    .div_start(div_start), .div_stall(div_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic mtr, mw, as, rd, rw, hw, dv;
    logic [AW-1:0] alu;
    logic v;
  } me_t;
  typedef struct packed { logic mtr, mw, rw, hw, v; } mm_t;
  typedef struct packed { logic mtr, rw, v; } mw_t;

  me_t me;
  mm_t mm;
  mw_t mw;
  int  age;          // -1: no divide running; 1..DC+1: cycles since launch
  int  n_cmp = 0, n_bad = 0;
  int  cnt_start = 0, cnt_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    me = '0; mm = '0; mw = '0; age = -1;
  endtask

  task automatic zero_in();
    {memtoregD, memwriteD, alusrcD, regdstD, regwriteD, hilo_writeD, divD} = '0;
    alucontrolD = '0;
    {branchD, equalD, stallD, stallE, stallM, flushE, flushM, flushW} = '0;
  endtask

  // One clock: compare at mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic ds, st, stE;
    me_t ne; mm_t nm; mw_t nw; int na;
    #3;
    if (!rst) model_reset();
    st  = (age == -1) && me.v && me.dv && !flushE;
    ds  = st || (age >= 1 && age <= DC);
    stE = stallE || ds;
    chk("pcsrcD", pcsrcD, branchD & equalD & ~stallD);
    chk("div_start", div_start, st);
    chk("div_stall", div_stall, ds);
    chk("E", {memtoregE, alusrcE, regdstE, regwriteE, alucontrolE, validE},
             {me.mtr, me.as, me.rd, me.rw, me.alu, me.v});
    chk("M", {memtoregM, memwriteM, regwriteM, hilo_writeM, validM}, mm);
    chk("W", {memtoregW, regwriteW, validW}, mw);
    cnt_start += int'(div_start);
    cnt_stall += int'(div_stall);
    ne = me;
    if (flushE) ne = '0;
    else if (!stE) ne = '{memtoregD, memwriteD, alusrcD, regdstD, regwriteD, hilo_writeD,
                          divD, alucontrolD, 1'b1};
    nm = mm;
    if (flushM) nm = '0;
    else if (!stallM) nm = stE ? mm_t'('0) : mm_t'({me.mtr, me.mw, me.rw, me.hw, me.v});
    nw = (flushW || stallM) ? mw_t'('0) : mw_t'({mm.mtr, mm.rw, mm.v});
    if (flushE)            na = -1;
    else if (age == -1)    na = st ? 1 : -1;
    else if (age <= DC)    na = age + 1;
    else                   na = stallE ? age : -1;
    @(posedge clk);
    if (!rst) model_reset();
    else begin me = ne; mm = nm; mw = nw; age = na; end
    #1;
  endtask

  task automatic idle(input int n);
    zero_in();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of run");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    zero_in();
    model_reset();
    @(posedge clk); #1;
    cycle(); cycle();
    chk("reset_validE", validE, 0);
    chk("reset_validW", validW, 0);
    chk("reset_div_stall", div_stall, 0);
    rst = 1'b1;
    idle(2);

    // ALU op flows E->M->W one stage per cycle
    alucontrolD = 5'h02; regwriteD = 1'b1;
    cycle(); zero_in();
    chk("alu_regwriteE_c1", regwriteE, 1);
    chk("alu_alucontrolE_c1", alucontrolE, 5'h02);
    cycle();
    chk("alu_regwriteM_c2", regwriteM, 1);
    cycle();
    chk("alu_regwriteW_c3", regwriteW, 1);
    chk("alu_validW_c3", validW, 1);
    idle(3);

    // Divide: one start pulse, 33 stall cycles, result reaches M on cycle 35
    cnt_start = 0; cnt_stall = 0;
    divD = 1'b1; hilo_writeD = 1'b1;
    cycle(); zero_in();
    for (int k = 1; k <= 34; k++) begin
      if (k == 34) chk("div_hilo_writeM_c34", hilo_writeM, 0);
      cycle();
    end
    chk("div_hilo_writeM_c35", hilo_writeM, 1);
    chk("div_start_count", cnt_start, 1);
    chk("div_stall_count", cnt_stall, 33);
    idle(3);

    // External stallE for 2 cycles: M sees two bubbles, then the op
    regwriteD = 1'b1;
    cycle(); zero_in();
    stallE = 1'b1;
    cycle();
    chk("stall_validM_b1", validM, 0);
    chk("stall_regwriteE_hold", regwriteE, 1);
    cycle();
    chk("stall_regwriteM_b2", regwriteM, 0);
    stallE = 1'b0;
    cycle();
    chk("stall_regwriteM_after", regwriteM, 1);
    chk("stall_validM_after", validM, 1);
    idle(3);

    // flushE beats stallE; flushE aborts a running divide
    regwriteD = 1'b1;
    cycle(); zero_in();
    stallE = 1'b1; flushE = 1'b1;
    cycle(); zero_in();
    chk("flush_over_stall_validE", validE, 0);
    divD = 1'b1;
    cycle(); zero_in();
    cycle(); cycle();
    #1 chk("busy_div_stall", div_stall, 1);
    flushE = 1'b1;
    cycle(); zero_in();
    #1 chk("flush_busy_div_stall", div_stall, 0);
    chk("flush_busy_validE", validE, 0);
    idle(3);

    // Branch resolution
    branchD = 1'b1; equalD = 1'b1;
    #1 chk("pcsrc_taken", pcsrcD, 1);
    stallD = 1'b1;
    #1 chk("pcsrc_stalled", pcsrcD, 0);
    cycle();
    idle(2);

    // Reset during BUSY at cnt=10, then a fresh full-length divide
    divD = 1'b1;
    cycle(); zero_in();
    for (int k = 1; k <= 22; k++) cycle();
    chk("pre_reset_div_stall", div_stall, 1);
    rst = 1'b0;
    #1;
    chk("rst_div_stall", div_stall, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_validE", validE, 0);
    chk("rst_validM_W", {validM, validW}, 0);
    cycle(); cycle();
    rst = 1'b1;
    cnt_start = 0; cnt_stall = 0;
    divD = 1'b1;
    cycle(); zero_in();
    for (int k = 1; k <= 34; k++) cycle();
    chk("post_rst_div_stall_count", cnt_stall, 33);
    chk("post_rst_div_start_count", cnt_start, 1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      {memtoregD, memwriteD, alusrcD, regdstD, regwriteD, hilo_writeD} = 6'($urandom);
      alucontrolD = AW'($urandom);
      divD    = ($urandom_range(0, 7) == 0);
      branchD = $urandom_range(0, 1) == 1;
      equalD  = $urandom_range(0, 1) == 1;
      stallD  = ($urandom_range(0, 3) == 0);
      stallE  = ($urandom_range(0, 7) == 0);
      stallM  = ($urandom_range(0, 11) == 0);
      flushE  = ($urandom_range(0, 19) == 0);
      flushM  = ($urandom_range(0, 19) == 0);
      flushW  = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_regs.md
PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

Interface
REQ-001 Parameter ALUCW, default 5, width of the ALU control field.
REQ-002 Parameter DIV_CYCLES, default 32, number of BUSY cycles for a multi-cycle divide (range 1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 memtoregD, memwriteD, alusrcD, regdstD, regwriteD, hilo_writeD, divD  in  1 each  decoded controls for the instruction in Decode.
REQ-006 alucontrolD  in  ALUCW  decoded ALU operation.
REQ-007 branchD, equalD  in  1 each  branch decode flag and register-compare result.
REQ-008 stallD, stallE, stallM  in  1 each  hazard-unit hold requests per stage.
REQ-009 flushE, flushM, flushW  in  1 each  hazard-unit bubble requests per stage.
REQ-010 pcsrcD  out  1  branch taken.
REQ-011 memtoregE, alusrcE, regdstE, regwriteE, validE  out  1 each; alucontrolE  out  ALUCW.
REQ-012 memtoregM, memwriteM, regwriteM, hilo_writeM, validM  out  1 each.
REQ-013 memtoregW, regwriteW, validW  out  1 each.
REQ-014 div_start  out  1  one-cycle pulse launching the external divider.
REQ-015 div_stall  out  1  request to hazard unit to hold Fetch/Decode/Execute.

Function
REQ-016 pcsrcD SHALL equal branchD & equalD & ~stallD (combinational).
REQ-017 Effective Execute hold stallE_eff SHALL be stallE | div_stall.
REQ-018 E register: flushE -> all fields 0, validE=0; else stallE_eff -> hold; else load D fields with validE=1; flush has priority over stall.
REQ-019 M register: flushM -> clear; else stallM -> hold; else stallE_eff -> load bubble (all 0); else load E fields and validE.
REQ-020 W register: flushW -> clear; else stallM -> load bubble; else load M fields and validM.
REQ-021 A bubble SHALL have every control bit 0, so no register, memory or HI/LO write occurs.
REQ-022 Divide FSM states IDLE, BUSY, DONE; 8-bit down-counter cnt.
REQ-023 IDLE: if validE & divE & ~flushE -> div_stall=1, div_start=1, next BUSY, cnt<=DIV_CYCLES-1; otherwise stay IDLE, div_stall=0.
REQ-024 BUSY: div_stall=1, div_start=0; cnt==0 -> DONE, else cnt decrements.
REQ-025 DONE: div_stall=0; if E advances (~stallE) -> IDLE, else stay DONE (no relaunch under external stall).
REQ-026 flushE in any state SHALL force next state IDLE and cnt 0; divide result is discarded.
REQ-027 A divide SHALL occupy Execute exactly DIV_CYCLES+2 cycles absent other stalls (34 at default).
REQ-028 divE is an internal E-stage copy of divD, cleared by bubbles like other fields.
REQ-029 Back-to-back divides SHALL each receive a separate div_start pulse.
REQ-030 div_start and div_stall SHALL be functions of state and E-stage registers only, never of D-stage inputs.

Reset
REQ-031 rst low SHALL immediately clear all E/M/W fields and valid bits, set FSM to IDLE, cnt to 0, div_start/div_stall to 0.
REQ-032 Reset asserted mid-divide SHALL abandon it; after release the block behaves as freshly reset.
REQ-033 First rising edge after rst deasserts SHALL perform normal loading.

Verification
REQ-034 ALU op (alucontrolD=5'h02, regwriteD=1) with no stalls -> regwriteE=1 at cycle 1, regwriteM at 2, regwriteW at 3; validW=1 at 3.
REQ-035 divD=1, hilo_writeD=1, DIV_CYCLES=32 -> div_start high 1 cycle, div_stall high 33 cycles, hilo_writeM=1 on cycle 35 after entry to E.
REQ-036 stallE=1 for 2 cycles with ALU op in E -> E holds, M receives 2 bubbles (regwriteM=0, validM=0), then op proceeds.
REQ-037 flushE and stallE asserted together -> E cleared (validE=0); divide in BUSY with flushE -> IDLE next cycle, div_stall=0.
REQ-038 branchD=1, equalD=1, stallD=0 -> pcsrcD=1; same with stallD=1 -> pcsrcD=0.
REQ-039 rst low during BUSY at cnt=10 -> all outputs 0 at once; new divide after release gets full DIV_CYCLES count.
